multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_ctrl_pkg.sv | 65 ++++++
 rtl/mc_ctrl_decode.sv | 82 ++++++++
 rtl/multicycle_control.sv | 110 +++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and
// the control-word encodings seen by the datapath.
package mc_ctrl_pkg;

  localparam logic [31:0] OpRtype = 32'd0;
  localparam logic [31:0] OpAddi  = 32'd1;
  localparam logic [31:0] OpLw    = 32'd2;
  localparam logic [31:0] OpSw    = 32'd3;
  localparam logic [31:0] OpBeq   = 32'd4;
  localparam logic [31:0] OpJ     = 32'd5;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StAddrI, StBranch, StJump,
    StMemRd, StMemWr, StWbR, StWbMem, StWbI
  } state_e;

  typedef enum logic [2:0] {
    OpcRtype, OpcAddi, OpcLw, OpcSw, OpcBeq, OpcJ, OpcIllegal
  } op_class_e;

  localparam logic [1:0] AluSrcBReg   = 2'b00;
  localparam logic [1:0] AluSrcBFour  = 2'b01;
  localparam logic [1:0] AluSrcBImm   = 2'b10;
  localparam logic [1:0] AluSrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // Opcode is zero-extended by the caller so one helper serves any OPCODE_W.
  function automatic op_class_e classify_op(logic [31:0] op);
    case (op)
      OpRtype: return OpcRtype;
      OpAddi:  return OpcAddi;
      OpLw:    return OpcLw;
      OpSw:    return OpcSw;
      OpBeq:   return OpcBeq;
      OpJ:     return OpcJ;
      default: return OpcIllegal;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (plus opcode and mem_ready) to the
// control word; everything is forced low while reset is held.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OpcodeW = 4
) (
  input  logic               rst_i,
  input  state_e             state_i,
  input  logic [OpcodeW-1:0] opcode_i,
  input  logic               mem_ready_i,
  output ctrl_t              ctrl_o
);

  op_class_e op_class;
  assign op_class = classify_op(32'(opcode_i));

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = AluSrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_source = PcSrcAlu;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b  = AluSrcBImmSh;
        ctrl_o.illegal_op = (op_class == OpcIllegal);
      end
      StExecR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBReg;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StAddrI: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBImm;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_source     = PcSrcAluOut;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_source  = PcSrcJump;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemRd: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StMemWr: begin
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      StWbR: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StWbMem: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StWbI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) ctrl_o = '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: state register, next-state logic and the
// retired-instruction counter; output decode lives in mc_ctrl_decode.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q;
  op_class_e         op_class;
  ctrl_t             ctrl;

  // The datapath qualifies pc_write_cond with zero; sequencing ignores it.
  logic unused_zero;
  assign unused_zero = zero;

  assign op_class = classify_op(32'(opcode));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op_class)
          OpcRtype:                state_d = StExecR;
          OpcAddi, OpcLw, OpcSw:   state_d = StAddrI;
          OpcBeq:                  state_d = StBranch;
          OpcJ:                    state_d = StJump;
          default:                 state_d = StFetch;
        endcase
      end
      StExecR:  state_d = StWbR;
      StAddrI: begin
        case (op_class)
          OpcLw:   state_d = StMemRd;
          OpcSw:   state_d = StMemWr;
          OpcAddi: state_d = StWbI;
          default: state_d = StFetch;
        endcase
      end
      StMemRd:  if (mem_ready) state_d = StWbMem;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StBranch, StJump, StWbR, StWbMem, StWbI: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl.instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  mc_ctrl_decode #(
    .OpcodeW(OPCODE_W)
  ) u_decode (
    .rst_i      (rst),
    .state_i    (state_q),
    .opcode_i   (opcode),
    .mem_ready_i(mem_ready),
    .ctrl_o     (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALU_OP_W'(ctrl.alu_op);
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign instr_done    = ctrl.instr_done;
  assign retired       = rst ? '0 : retired_q;

endmodule
